cia_tod_ctrl: RTL and testbench

Sequencer and bus arbiter in front of a CIA time-of-day (TOD) timer. It generates the timer's `count` strobe from an asynchronous tick input. It shares the timer's register port between the CPU bus and a host command channel, which can atomically load the 24-bit TOD counter or alarm, or read the counter. It sits between the CIA register decoder and the TOD timer, and passes CPU accesses through unchanged.

---
 rtl/cia_pkg.sv | 43 ++++
 rtl/cia_tod_tick.sv | 48 ++++
 rtl/cia_tod_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_cia_tod_ctrl.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cia_pkg.sv
// Shared definitions for the CIA TOD controller: command encodings, FSM states
// and the timer register-port bundle driven by the sequencer.
package cia_pkg;

    localparam logic [1:0] OP_LOAD_TOD   = 2'b00;
    localparam logic [1:0] OP_LOAD_ALARM = 2'b01;
    localparam logic [1:0] OP_READ_TOD   = 2'b10;
    localparam logic [1:0] OP_RESERVED   = 2'b11;

    // Control-register bit that steers TOD writes into the alarm registers.
    localparam int CR_ALARM_BIT = 7;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_RD_CR,
        ST_WR_CR,
        ST_WR_HI,
        ST_WR_MI,
        ST_WR_LO,
        ST_RESTORE,
        ST_RD_HI,
        ST_RD_MI,
        ST_RD_LO,
        ST_DONE
    } tod_state_e;

    typedef struct packed {
        logic       wr;
        logic       tlo;
        logic       tme;
        logic       thi;
        logic       tcr;
        logic [7:0] data;
    } tbus_t;

    function automatic logic [7:0] cr_value(input logic alarm_bit);
        logic [7:0] v;
        v = 8'h00;
        v[CR_ALARM_BIT] = alarm_bit;
        return v;
    endfunction

endpackage

// File: rtl/cia_tod_tick.sv
// TOD tick front end: two-flop synchronizer, rising-edge detector and a
// TICK_DIV edge divider producing a registered one-cycle tick.
module cia_tod_tick #(
    parameter int TICK_DIV = 1
) (
    input  logic clk,
    input  logic clk7_en,
    input  logic reset,
    input  logic tick_in,
    output logic tick
);

    // [0],[1] synchronize; [2] holds the previous synchronized level
    logic [2:0] sync_q, sync_d;
    logic [7:0] div_q, div_d;
    logic       tick_q, tick_d;
    logic       edge_det;

    always_comb begin
        sync_d   = {sync_q[1:0], tick_in};
        edge_det = sync_q[1] & ~sync_q[2];
        div_d    = div_q;
        tick_d   = 1'b0;
        if (edge_det) begin
            if (div_q == 8'(TICK_DIV - 1)) begin
                div_d  = 8'h00;
                tick_d = 1'b1;
            end else begin
                div_d = div_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= 3'b000;
            div_q  <= 8'h00;
            tick_q <= 1'b0;
        end else if (clk7_en) begin
            sync_q <= sync_d;
            div_q  <= div_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/cia_tod_ctrl.sv
// Sequencer/arbiter in front of a CIA TOD timer: CPU pass-through with
// priority, atomic host load/read sequences, and deferred count strobes.
module cia_tod_ctrl
    import cia_pkg::*;
#(
    parameter int TICK_DIV = 1
) (
    input  logic        clk,
    input  logic        clk7_en,
    input  logic        reset,
    input  logic        tick_in,
    input  logic        cpu_wr,
    input  logic        cpu_tlo,
    input  logic        cpu_tme,
    input  logic        cpu_thi,
    input  logic        cpu_tcr,
    input  logic [7:0]  cpu_data_in,
    output logic [7:0]  cpu_data_out,
    input  logic        cmd_req,
    input  logic [1:0]  cmd_op,
    input  logic [23:0] cmd_data,
    output logic        cmd_ack,
    output logic [23:0] cmd_rdata,
    output logic        t_wr,
    output logic        t_tlo,
    output logic        t_tme,
    output logic        t_thi,
    output logic        t_tcr,
    output logic [7:0]  t_data_in,
    input  logic [7:0]  t_data_out,
    output logic        t_count
);

    tod_state_e  state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic [23:0] data_q, data_d;
    logic [23:0] shadow_q, shadow_d;
    logic [23:0] rdata_q, rdata_d;
    logic        crb_sav_q, crb_sav_d;
    logic        pend_q, pend_d;

    logic        tick;
    logic        cpu_sel;
    logic        stall;
    logic        mid_seq;
    tbus_t       fsm_bus;

    cia_tod_tick #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk     (clk),
        .clk7_en (clk7_en),
        .reset   (reset),
        .tick_in (tick_in),
        .tick    (tick)
    );

    assign cpu_sel = cpu_tlo | cpu_tme | cpu_thi | cpu_tcr;
    // DONE makes no access, so it never stalls; this keeps cmd_ack one cycle.
    assign stall   = cpu_sel && (state_q != ST_DONE);

    assign mid_seq = (state_q == ST_WR_CR) || (state_q == ST_WR_HI) ||
                     (state_q == ST_WR_MI) || (state_q == ST_WR_LO) ||
                     (state_q == ST_RD_HI) || (state_q == ST_RD_MI) ||
                     (state_q == ST_RD_LO);

    always_comb begin
        fsm_bus = '0;
        case (state_q)
            ST_RD_CR: fsm_bus.tcr = 1'b1;
            ST_WR_CR: begin
                fsm_bus.wr   = 1'b1;
                fsm_bus.tcr  = 1'b1;
                fsm_bus.data = cr_value(op_q == OP_LOAD_ALARM);
            end
            ST_WR_HI: begin
                fsm_bus.wr   = 1'b1;
                fsm_bus.thi  = 1'b1;
                fsm_bus.data = data_q[23:16];
            end
            ST_WR_MI: begin
                fsm_bus.wr   = 1'b1;
                fsm_bus.tme  = 1'b1;
                fsm_bus.data = data_q[15:8];
            end
            ST_WR_LO: begin
                fsm_bus.wr   = 1'b1;
                fsm_bus.tlo  = 1'b1;
                fsm_bus.data = data_q[7:0];
            end
            ST_RESTORE: begin
                fsm_bus.wr   = 1'b1;
                fsm_bus.tcr  = 1'b1;
                fsm_bus.data = cr_value(crb_sav_q);
            end
            ST_RD_HI: fsm_bus.thi = 1'b1;
            ST_RD_MI: fsm_bus.tme = 1'b1;
            ST_RD_LO: fsm_bus.tlo = 1'b1;
            default:  fsm_bus = '0;
        endcase
    end

    always_comb begin
        if (cpu_sel) begin
            t_wr      = cpu_wr;
            t_tlo     = cpu_tlo;
            t_tme     = cpu_tme;
            t_thi     = cpu_thi;
            t_tcr     = cpu_tcr;
            t_data_in = cpu_data_in;
        end else begin
            t_wr      = fsm_bus.wr;
            t_tlo     = fsm_bus.tlo;
            t_tme     = fsm_bus.tme;
            t_thi     = fsm_bus.thi;
            t_tcr     = fsm_bus.tcr;
            t_data_in = fsm_bus.data;
        end
    end

    assign cpu_data_out = cpu_sel ? t_data_out : 8'h00;

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        data_d    = data_q;
        shadow_d  = shadow_q;
        rdata_d   = rdata_q;
        crb_sav_d = crb_sav_q;

        // A CPU control write inside the sequence becomes the value RESTORE puts back.
        if (cpu_sel && cpu_wr && cpu_tcr && mid_seq) begin
            crb_sav_d = cpu_data_in[CR_ALARM_BIT];
        end

        if (!stall) begin
            case (state_q)
                ST_IDLE: begin
                    if (cmd_req) begin
                        op_d    = cmd_op;
                        data_d  = cmd_data;
                        state_d = (cmd_op == OP_RESERVED) ? ST_DONE : ST_RD_CR;
                    end
                end
                ST_RD_CR: begin
                    crb_sav_d = t_data_out[CR_ALARM_BIT];
                    state_d   = ST_WR_CR;
                end
                ST_WR_CR:   state_d = (op_q == OP_READ_TOD) ? ST_RD_HI : ST_WR_HI;
                ST_WR_HI:   state_d = ST_WR_MI;
                ST_WR_MI:   state_d = ST_WR_LO;
                ST_WR_LO:   state_d = ST_RESTORE;
                ST_RD_HI: begin
                    shadow_d[23:16] = t_data_out;
                    state_d         = ST_RD_MI;
                end
                ST_RD_MI: begin
                    shadow_d[15:8] = t_data_out;
                    state_d        = ST_RD_LO;
                end
                ST_RD_LO: begin
                    shadow_d[7:0] = t_data_out;
                    state_d       = ST_RESTORE;
                end
                ST_RESTORE: begin
                    // Publish on entry to DONE so the result is valid alongside cmd_ack.
                    if (op_q == OP_READ_TOD) begin
                        rdata_d = shadow_q;
                    end
                    state_d = ST_DONE;
                end
                ST_DONE:    state_d = ST_IDLE;
                default:    state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        pend_d  = pend_q;
        t_count = 1'b0;
        if (state_q == ST_IDLE) begin
            t_count = tick | pend_q;
            pend_d  = tick & pend_q;
        end else if (tick) begin
            pend_d = 1'b1;
        end
    end

    assign cmd_ack   = (state_q == ST_DONE);
    assign cmd_rdata = rdata_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            op_q      <= OP_LOAD_TOD;
            data_q    <= 24'h000000;
            shadow_q  <= 24'h000000;
            rdata_q   <= 24'h000000;
            crb_sav_q <= 1'b0;
            pend_q    <= 1'b0;
        end else if (clk7_en) begin
            state_q   <= state_d;
            op_q      <= op_d;
            data_q    <= data_d;
            shadow_q  <= shadow_d;
            rdata_q   <= rdata_d;
            crb_sav_q <= crb_sav_d;
            pend_q    <= pend_d;
        end
    end

endmodule

// File: tb/tb_cia_tod_ctrl.sv
// Scoreboard bench for cia_tod_ctrl: stimulus pushes expected timer-bus writes,
// CPU read data, acks and count strobes; a negedge monitor pops and compares.
module tb_cia_tod_ctrl;
    import cia_pkg::*;

    logic        clk = 1'b0;
    logic        clk7_en = 1'b1;
    logic        reset = 1'b1;
    logic        tick_in = 1'b0;
    logic        cpu_wr = 1'b0;
    logic        cpu_tlo = 1'b0;
    logic        cpu_tme = 1'b0;
    logic        cpu_thi = 1'b0;
    logic        cpu_tcr = 1'b0;
    logic [7:0]  cpu_data_in = 8'h00;
    logic [7:0]  cpu_data_out;
    logic        cmd_req = 1'b0;
    logic [1:0]  cmd_op = 2'b00;
    logic [23:0] cmd_data = 24'h000000;
    logic        cmd_ack;
    logic [23:0] cmd_rdata;
    logic        t_wr, t_tlo, t_tme, t_thi, t_tcr, t_count;
    logic [7:0]  t_data_in;
    logic [7:0]  t_data_out;

    always #5 clk = ~clk;

    cia_tod_ctrl #(.TICK_DIV(1)) dut (
        .clk          (clk),
        .clk7_en      (clk7_en),
        .reset        (reset),
        .tick_in      (tick_in),
        .cpu_wr       (cpu_wr),
        .cpu_tlo      (cpu_tlo),
        .cpu_tme      (cpu_tme),
        .cpu_thi      (cpu_thi),
        .cpu_tcr      (cpu_tcr),
        .cpu_data_in  (cpu_data_in),
        .cpu_data_out (cpu_data_out),
        .cmd_req      (cmd_req),
        .cmd_op       (cmd_op),
        .cmd_data     (cmd_data),
        .cmd_ack      (cmd_ack),
        .cmd_rdata    (cmd_rdata),
        .t_wr         (t_wr),
        .t_tlo        (t_tlo),
        .t_tme        (t_tme),
        .t_thi        (t_thi),
        .t_tcr        (t_tcr),
        .t_data_in    (t_data_in),
        .t_data_out   (t_data_out),
        .t_count      (t_count)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Minimal TOD timer: counter and control register; alarm writes are discarded.
    logic [23:0] m_tod;
    logic [7:0]  m_cr;
    always @(posedge clk) begin
        if (reset) begin
            m_tod <= 24'h000000;
            m_cr  <= 8'h00;
        end else if (clk7_en) begin
            if (t_wr && t_tcr) m_cr <= t_data_in;
            if (t_wr && !m_cr[7]) begin
                if (t_thi) m_tod[23:16] <= t_data_in;
                if (t_tme) m_tod[15:8]  <= t_data_in;
                if (t_tlo) m_tod[7:0]   <= t_data_in;
            end
            if (t_count) m_tod <= m_tod + 24'd1;
        end
    end

    always_comb begin
        t_data_out = 8'h00;
        if (t_tcr)      t_data_out = m_cr;
        else if (t_thi) t_data_out = m_tod[23:16];
        else if (t_tme) t_data_out = m_tod[15:8];
        else if (t_tlo) t_data_out = m_tod[7:0];
    end

    typedef struct packed {
        logic [3:0] sel;   // {tcr, thi, tme, tlo}
        logic [7:0] data;
    } wr_t;

    typedef struct packed {
        logic [31:0] cyc;
        logic [23:0] rdata;
        logic        chk;
    } ack_t;

    wr_t        wr_q[$];
    ack_t       ack_q[$];
    int         cnt_q[$];
    logic [7:0] rd_q[$];
    wr_t        mon_wr;
    ack_t       mon_ack;
    int         mon_cnt;
    logic [7:0] mon_rd;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end else begin
            $display("ok   %s: 0x%0h (cycle %0d)", name, act, cyc);
        end
    endtask

    task automatic unexpected(input string name, input logic [31:0] act);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got 0x%0h with nothing expected (cycle %0d)", name, act, cyc);
    endtask

    always @(negedge clk) begin
        if (clk7_en) begin
            if (t_wr) begin
                if (wr_q.size() == 0) unexpected("bus_write", {20'h0, t_tcr, t_thi, t_tme, t_tlo, t_data_in});
                else begin
                    mon_wr = wr_q.pop_front();
                    check("bus_write", {20'h0, t_tcr, t_thi, t_tme, t_tlo, t_data_in}, {20'h0, mon_wr});
                end
            end
            if (t_count) begin
                if (cnt_q.size() == 0) unexpected("t_count_cycle", cyc);
                else begin
                    mon_cnt = cnt_q.pop_front();
                    check("t_count_cycle", cyc, mon_cnt);
                end
            end
            if (cmd_ack) begin
                if (ack_q.size() == 0) unexpected("ack_cycle", cyc);
                else begin
                    mon_ack = ack_q.pop_front();
                    check("ack_cycle", cyc, mon_ack.cyc);
                    if (mon_ack.chk) check("cmd_rdata", {8'h0, cmd_rdata}, {8'h0, mon_ack.rdata});
                end
            end
            if ((cpu_tlo | cpu_tme | cpu_thi | cpu_tcr) && !cpu_wr) begin
                if (rd_q.size() == 0) unexpected("cpu_read", {24'h0, cpu_data_out});
                else begin
                    mon_rd = rd_q.pop_front();
                    check("cpu_read", {24'h0, cpu_data_out}, {24'h0, mon_rd});
                end
            end
        end
    end

    task automatic push_wr(input logic [3:0] sel, input logic [7:0] data);
        wr_q.push_back(wr_t'{sel, data});
    endtask

    task automatic run_cmd(input logic [1:0] op, input logic [23:0] d, input int lat,
                           input logic [23:0] rd, input logic chk);
        int  p;
        bit  seen;
        seen = 1'b0;
        @(posedge clk); #1;
        cmd_req  = 1'b1;
        cmd_op   = op;
        cmd_data = d;
        p = cyc;
        ack_q.push_back(ack_t'{32'(p + lat), rd, chk});
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (cmd_ack) seen = 1'b1;
        end
        if (!seen) unexpected("ack_timeout", 32'(p));
        @(posedge clk); #1;
        cmd_req  = 1'b0;
        cmd_data = 24'h5a5a5a;
    endtask

    task automatic cpu_write(input logic [3:0] sel, input logic [7:0] data);
        @(posedge clk); #1;
        {cpu_tcr, cpu_thi, cpu_tme, cpu_tlo} = sel;
        cpu_wr      = 1'b1;
        cpu_data_in = data;
        @(posedge clk); #1;
        {cpu_tcr, cpu_thi, cpu_tme, cpu_tlo} = 4'b0000;
        cpu_wr = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tbus", {19'h0, t_wr, t_tlo, t_tme, t_thi, t_tcr, t_data_in}, 32'h0);
        check("rst_count_ack", {30'h0, t_count, cmd_ack}, 32'h0);
        check("rst_rdata", {8'h0, cmd_rdata}, 32'h0);
        check("rst_cpu_out", {24'h0, cpu_data_out}, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (3) @(posedge clk);

        // Free-running ticks, idle bus: one strobe per rising edge, three cycles later
        for (int e = 0; e < 4; e++) begin
            @(posedge clk); #1;
            tick_in = 1'b1;
            cnt_q.push_back(cyc + 3);
            repeat (20) @(posedge clk); #1;
            tick_in = 1'b0;
            repeat (19) @(posedge clk);
        end

        // LOAD_TOD with the alarm bit previously set
        push_wr(4'b1000, 8'h80);
        cpu_write(4'b1000, 8'h80);
        push_wr(4'b1000, 8'h00);
        push_wr(4'b0100, 8'h12);
        push_wr(4'b0010, 8'h34);
        push_wr(4'b0001, 8'h56);
        push_wr(4'b1000, 8'h80);
        run_cmd(OP_LOAD_TOD, 24'h123456, 7, 24'h0, 1'b0);

        // LOAD_ALARM with the alarm bit previously clear
        push_wr(4'b1000, 8'h00);
        cpu_write(4'b1000, 8'h00);
        push_wr(4'b1000, 8'h80);
        push_wr(4'b0100, 8'hab);
        push_wr(4'b0010, 8'hcd);
        push_wr(4'b0001, 8'hef);
        push_wr(4'b1000, 8'h00);
        run_cmd(OP_LOAD_ALARM, 24'habcdef, 7, 24'h0, 1'b0);

        push_wr(4'b1000, 8'h00);
        push_wr(4'b0100, 8'h00);
        push_wr(4'b0010, 8'hff);
        push_wr(4'b0001, 8'hff);
        push_wr(4'b1000, 8'h00);
        run_cmd(OP_LOAD_TOD, 24'h00ffff, 7, 24'h0, 1'b0);

        // READ_TOD with a tick landing in RD_MI: strobe deferred to first IDLE cycle
        push_wr(4'b1000, 8'h00);
        push_wr(4'b1000, 8'h00);
        fork
            run_cmd(OP_READ_TOD, 24'h0, 7, 24'h00ffff, 1'b1);
            begin
                repeat (2) @(posedge clk); #1;
                tick_in = 1'b1;
                cnt_q.push_back(cyc + 7);
                repeat (3) @(posedge clk); #1;
                tick_in = 1'b0;
            end
        join

        // The deferred strobe advanced the timer
        push_wr(4'b1000, 8'h00);
        push_wr(4'b1000, 8'h00);
        run_cmd(OP_READ_TOD, 24'h0, 7, 24'h010000, 1'b1);

        run_cmd(OP_RESERVED, 24'h777777, 1, 24'h0, 1'b0);
        @(negedge clk);
        check("rdata_hold", {8'h0, cmd_rdata}, 32'h00010000);

        // CPU accesses every other cycle, including a control write mid-sequence
        rd_q.push_back(8'h01);
        rd_q.push_back(8'h00);
        push_wr(4'b1000, 8'h00);
        push_wr(4'b0100, 8'h65);
        push_wr(4'b1000, 8'h80);
        push_wr(4'b0010, 8'h43);
        push_wr(4'b0001, 8'h21);
        push_wr(4'b1000, 8'h80);
        fork
            run_cmd(OP_LOAD_TOD, 24'h654321, 10, 24'h0, 1'b0);
            begin
                repeat (3) @(posedge clk); #1;
                cpu_thi = 1'b1;
                @(posedge clk); #1;
                cpu_thi = 1'b0;
                @(posedge clk); #1;
                cpu_tcr = 1'b1;
                @(posedge clk); #1;
                cpu_tcr = 1'b0;
                @(posedge clk); #1;
                cpu_tcr     = 1'b1;
                cpu_wr      = 1'b1;
                cpu_data_in = 8'h80;
                @(posedge clk); #1;
                cpu_tcr = 1'b0;
                cpu_wr  = 1'b0;
            end
        join

        // Reset while in WR_MI with a pending tick: abort, no ack, no strobe
        push_wr(4'b1000, 8'h00);
        push_wr(4'b0100, 8'h11);
        push_wr(4'b0010, 8'h11);
        @(posedge clk); #1;
        cmd_req  = 1'b1;
        cmd_op   = OP_LOAD_TOD;
        cmd_data = 24'h111111;
        tick_in  = 1'b1;
        p = cyc;
        @(posedge clk); #1;
        @(posedge clk); #1;
        tick_in = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset   = 1'b1;
        cmd_req = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("abort_cycle", cyc, 32'(p + 5));
        check("abort_tbus", {19'h0, t_wr, t_tlo, t_tme, t_thi, t_tcr, t_data_in}, 32'h0);
        check("abort_count_ack", {30'h0, t_count, cmd_ack}, 32'h0);
        check("abort_rdata", {8'h0, cmd_rdata}, 32'h0);
        repeat (20) @(posedge clk);
        @(negedge clk);

        check("wr_q_drained", 32'(wr_q.size()), 32'h0);
        check("ack_q_drained", 32'(ack_q.size()), 32'h0);
        check("cnt_q_drained", 32'(cnt_q.size()), 32'h0);
        check("rd_q_drained", 32'(rd_q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
